// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit peripheral: register offsets,
// STATUS bit positions and the shifter state encoding.
package uart_pkg;

    localparam logic [1:0] UART_TXDATA  = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_BAUDDIV = 2'd2;
    localparam logic [1:0] UART_CTRL    = 2'd3;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVERRUN = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_periph_if.sv
// Core-side register bus for the UART window: decoder select, strobes,
// address/data and the one-cycle completion pulse.
interface uart_tx_periph_if;
    logic        sel;
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (output sel, we, re, addr, wdata, input rdata, ready);
    modport slave  (input sel, we, re, addr, wdata, output rdata, ready);
endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with full/empty/count; a push while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: register file with 1-cycle bus completion,
// TX FIFO, per-frame latched baud counter and an 8N1 shifter FSM.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_periph_if.slave    bus,
    output logic               tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic        acc, wr, rd, wr_tx;
    logic [1:0]  reg_sel;
    logic [15:0] bauddiv;
    logic        txen, overrun, ovr_set;
    logic [3:0]  status;
    logic [31:0] rd_mux;

    logic        fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic [CW-1:0] fifo_count;

    tx_state_e   state, state_nx;
    logic [15:0] div_frame, baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        bit_done, can_start;

    // A write with re also high is a plain write; it never updates rdata.
    assign acc     = bus.sel & (bus.we | bus.re);
    assign wr      = bus.sel & bus.we;
    assign rd      = bus.sel & bus.re & ~bus.we;
    assign reg_sel = bus.addr[3:2];
    assign wr_tx   = wr && (reg_sel == UART_TXDATA);
    assign ovr_set = wr_tx & fifo_full & ~fifo_pop;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_tx),
        .din   (bus.wdata[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status              = '0;
        status[ST_FULL]     = fifo_full;
        status[ST_EMPTY]    = fifo_empty;
        status[ST_BUSY]     = (state != S_IDLE);
        status[ST_OVERRUN]  = overrun;
        rd_mux = '0;
        case (reg_sel)
            UART_STATUS:  rd_mux = {28'd0, status};
            UART_BAUDDIV: rd_mux = {16'd0, bauddiv};
            UART_CTRL:    rd_mux = {31'd0, txen};
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bauddiv   <= DEFAULT_DIV;
            txen      <= 1'b1;
            overrun   <= 1'b0;
            bus.ready <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.ready <= acc;
            if (rd) bus.rdata <= rd_mux;
            if (wr && reg_sel == UART_BAUDDIV) bauddiv <= bus.wdata[15:0];
            if (wr && reg_sel == UART_CTRL)    txen    <= bus.wdata[0];
            // A new overrun beats a simultaneous clear.
            if (ovr_set)
                overrun <= 1'b1;
            else if (wr && reg_sel == UART_STATUS && bus.wdata[ST_OVERRUN])
                overrun <= 1'b0;
        end
    end

    assign bit_done  = (baud_cnt == div_frame);
    assign can_start = txen & ~fifo_empty;

    always_comb begin
        state_nx = state;
        fifo_pop = 1'b0;
        case (state)
            S_IDLE: if (can_start) begin
                fifo_pop = 1'b1;
                state_nx = S_START;
            end
            S_START: if (bit_done) state_nx = S_DATA;
            S_DATA:  if (bit_done && bit_idx == 3'd7) state_nx = S_STOP;
            S_STOP: if (bit_done) begin
                if (can_start) begin
                    fifo_pop = 1'b1;
                    state_nx = S_START;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // tx trails the state by one flop so the line level is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tx        <= 1'b1;
            div_frame <= '0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
        end else begin
            state <= state_nx;
            tx    <= (state == S_START) ? 1'b0 :
                     (state == S_DATA)  ? shreg[0] : 1'b1;
            if (fifo_pop) begin
                shreg     <= fifo_dout;
                div_frame <= bauddiv;
                baud_cnt  <= '0;
                bit_idx   <= '0;
            end else if (state != S_IDLE) begin
                if (bit_done) begin
                    baud_cnt <= '0;
                    if (state == S_DATA) begin
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                end else begin
                    baud_cnt <= baud_cnt + 1'b1;
                end
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:16], fifo_count};

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: register access, frame shape/timing,
// FIFO full/overrun, divisor change mid-frame and reset mid-frame.
module tb_uart_tx_periph;

    localparam logic [3:0] A_TX = 4'h0;
    localparam logic [3:0] A_ST = 4'h4;
    localparam logic [3:0] A_BD = 4'h8;
    localparam logic [3:0] A_CT = 4'hC;

    logic clk = 1'b0;
    logic rst;
    logic tx;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   e;
    int   e0;
    logic txlog [0:8191];

    uart_tx_periph_if bus();

    uart_tx_periph #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd867)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    // cyc counts rising edges; txlog[n] is the line level after edge n.
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < 8192) txlog[cyc] = tx;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.sel = 1'b0;
        bus.we  = 1'b0;
        bus.re  = 1'b0;
    endtask

    task automatic wr(logic [3:0] a, logic [31:0] d);
        bus.sel = 1'b1; bus.we = 1'b1; bus.re = 1'b0;
        bus.addr = a; bus.wdata = d;
        @(negedge clk);
        chk("wr_ready", 32'(bus.ready), 32'd1);
        idle_bus();
    endtask

    task automatic rd(logic [3:0] a, string tag, logic [31:0] exp);
        bus.sel = 1'b1; bus.we = 1'b0; bus.re = 1'b1;
        bus.addr = a;
        @(negedge clk);
        chk("rd_ready", 32'(bus.ready), 32'd1);
        chk(tag, bus.rdata, exp);
        idle_bus();
    endtask

    task automatic wait_until(int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Count cycles of an 8N1 frame starting at log index s that differ from expected.
    function automatic int frame_errs(int s, int d, logic [7:0] b);
        int errs = 0;
        for (int k = 0; k < 10 * (d + 1); k++) begin
            int   bi = k / (d + 1);
            logic exp_bit = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
            if (txlog[s+k] !== exp_bit) errs++;
        end
        return errs;
    endfunction

    function automatic int idle_errs(int s, int n);
        int errs = 0;
        for (int k = 0; k < n; k++) if (txlog[s+k] !== 1'b1) errs++;
        return errs;
    endfunction

    initial begin
        logic [7:0] b;
        idle_bus();
        bus.addr = '0;
        bus.wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        rst = 1'b0;

        // reset values
        rd(A_TX, "rd_txdata", 32'd0);
        rd(A_ST, "rd_status", 32'h2);
        rd(A_BD, "rd_baud", 32'd867);
        rd(A_CT, "rd_ctrl", 32'h1);
        @(negedge clk);
        chk("ready_one_cycle", 32'(bus.ready), 32'd0);

        // access without sel is ignored
        bus.sel = 1'b0; bus.we = 1'b1; bus.addr = A_BD; bus.wdata = 32'd5;
        @(negedge clk);
        chk("nosel_ready", 32'(bus.ready), 32'd0);
        idle_bus();
        rd(A_BD, "nosel_baud", 32'd867);

        // we+re together is a write; rdata holds the previous read
        bus.sel = 1'b1; bus.we = 1'b1; bus.re = 1'b1; bus.addr = A_BD; bus.wdata = 32'd3;
        @(negedge clk);
        chk("wrre_ready", 32'(bus.ready), 32'd1);
        chk("wrre_rdata", bus.rdata, 32'd867);
        idle_bus();
        @(negedge clk);
        chk("rdata_hold", bus.rdata, 32'd867);
        rd(A_BD, "baud3", 32'd3);

        // single frame 0xA5 at divisor 3
        wr(A_TX, 32'hA5);
        e = cyc;
        repeat (5) @(negedge clk);
        rd(A_ST, "busy", 32'h6);
        wait_until(e + 46);
        rd(A_ST, "empty_after", 32'h2);
        chk("pre_frame_high", 32'(txlog[e+1]), 32'd1);
        chk("frame_a5", 32'(frame_errs(e + 2, 3, 8'hA5)), 32'd0);
        chk("post_a5_high", 32'(txlog[e+42]), 32'd1);

        // TXEN=0: fill and overrun, then release four back-to-back frames
        wr(A_CT, 32'd0);
        e0 = cyc;
        for (int i = 0; i < 6; i++) wr(A_TX, 32'(17 * (i + 1)));
        rd(A_ST, "full_ovr", 32'h9);
        wr(A_CT, 32'd1);
        e = cyc;
        chk("disabled_idle", 32'(idle_errs(e0, e - e0)), 32'd0);
        wait_until(e + 2 + 160 + 45);
        for (int n = 0; n < 4; n++) begin
            b = 8'(17 * (n + 1));
            chk("burst_frame", 32'(frame_errs(e + 2 + 40 * n, 3, b)), 32'd0);
        end
        chk("burst_no_fifth", 32'(idle_errs(e + 162, 40)), 32'd0);
        rd(A_ST, "ovr_sticky", 32'hA);
        wr(A_ST, 32'h8);
        rd(A_ST, "ovr_w1c", 32'h2);

        // push into a full FIFO on the same edge the shifter pops
        wr(A_CT, 32'd0);
        for (int i = 1; i <= 4; i++) wr(A_TX, 32'(i));
        wr(A_CT, 32'd1);
        e = cyc;
        wr(A_TX, 32'd5);
        rd(A_ST, "push_pop_full", 32'h5);
        wait_until(e + 2 + 200 + 10);
        for (int n = 0; n < 5; n++) begin
            b = 8'(n + 1);
            chk("pushpop_frame", 32'(frame_errs(e + 2 + 40 * n, 3, b)), 32'd0);
        end
        chk("pushpop_idle", 32'(idle_errs(e + 202, 8)), 32'd0);
        rd(A_ST, "pushpop_drain", 32'h2);

        // divisor change mid-frame applies to the next frame only
        wr(A_TX, 32'h3C);
        e = cyc;
        wr(A_TX, 32'hC3);
        repeat (10) @(negedge clk);
        wr(A_BD, 32'd7);
        wait_until(e + 2 + 40 + 80 + 10);
        chk("div_old_frame", 32'(frame_errs(e + 2, 3, 8'h3C)), 32'd0);
        chk("div_new_frame", 32'(frame_errs(e + 42, 7, 8'hC3)), 32'd0);
        chk("div_idle", 32'(idle_errs(e + 122, 8)), 32'd0);
        rd(A_BD, "baud7", 32'd7);

        // reset in the middle of DATA
        wr(A_TX, 32'h00);
        e = cyc;
        wr(A_TX, 32'h00);
        wr(A_TX, 32'h00);
        wait_until(e + 30);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 32'(bus.ready), 32'd0);
        chk("midrst_rdata", bus.rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_was_low", 32'(txlog[e+29]), 32'd0);
        chk("midrst_tx_high", 32'(txlog[e+31]), 32'd1);
        rd(A_ST, "midrst_status", 32'h2);
        rd(A_BD, "midrst_baud", 32'd867);
        rd(A_CT, "midrst_ctrl", 32'h1);
        repeat (200) @(negedge clk);
        chk("midrst_no_frame", 32'(idle_errs(e + 31, 200)), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
